multi_channel_debouncer: RTL and testbench

//   N-channel successor to the single-input debouncer. Each channel has a 2-FF synchroniser,

---
 rtl/multi_channel_debouncer.sv | 122 ++++++++++++
 tb/tb_multi_channel_debouncer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multi_channel_debouncer.sv
// N-channel debouncer: 2-FF synchroniser, per-channel polarity, debounce counter, rise/fall pulses.
// Optional auto-repeat while held is built only when the HOLD_REPEAT_EN macro is defined.
module multi_channel_debouncer #(
  parameter int                  CHANNELS      = 4,
  parameter int                  CNT_W         = 20,
  parameter int                  DEBOUNCE_TIME = 50000,
  parameter logic [CHANNELS-1:0] INVERT_MASK   = '0,
  parameter int                  HOLD_TIME     = 25000000,
  parameter int                  REPEAT_TIME   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] noisy_in,
  output logic [CHANNELS-1:0] stable_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TIME - 1);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("CHANNELS must be at least 1");
  end
  if (DEBOUNCE_TIME < 1 || DEBOUNCE_TIME > (2 ** CNT_W) - 1) begin : g_bad_debounce
    $error("DEBOUNCE_TIME must be in 1 .. 2**CNT_W-1");
  end
  if (HOLD_TIME < 1 || REPEAT_TIME < 1) begin : g_bad_hold
    $error("HOLD_TIME and REPEAT_TIME must be at least 1");
  end

  logic [CHANNELS-1:0] logical_in;
  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync_q;

  // Inversion happens before synchronisation so everything downstream is active-high.
  assign logical_in = noisy_in ^ INVERT_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= logical_in;
      sync_q    <= sync_meta;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             stable_r;
    logic             rise_r;
    logic             fall_r;
    logic             mismatch;
    logic             flip;

    assign mismatch = sync_q[i] ^ stable_r;
    assign flip     = mismatch && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt      <= '0;
        stable_r <= 1'b0;
        rise_r   <= 1'b0;
        fall_r   <= 1'b0;
      end else begin
        rise_r <= flip && sync_q[i];
        fall_r <= flip && !sync_q[i];
        // A bounce or a completed flip both restart the count from zero.
        if (!mismatch || flip) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (flip) begin
          stable_r <= sync_q[i];
        end
      end
    end

    assign stable_out[i] = stable_r;
    assign rise_pulse[i] = rise_r;
    assign fall_pulse[i] = fall_r;

`ifdef HOLD_REPEAT_EN
    localparam int HOLD_MAX = (HOLD_TIME > REPEAT_TIME) ? HOLD_TIME : REPEAT_TIME;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIME - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TIME - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              repeating;
    logic              rep_r;

    // hold_cnt measures cycles since the rise (or since the last repeat); a falling flip clears it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
        rep_r     <= 1'b0;
      end else begin
        rep_r <= 1'b0;
        if (!stable_r || flip) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (hold_cnt == (repeating ? REP_LAST : HOLD_LAST)) begin
          hold_cnt  <= '0;
          repeating <= 1'b1;
          rep_r     <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end

    assign repeat_pulse[i] = rep_r;
`else
    assign repeat_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench for multi_channel_debouncer: directed scenarios plus random toggling, checked every
// cycle against a window-based reference model of the debounce rule.
module tb_multi_channel_debouncer;

  localparam int         CH   = 4;
  localparam int         D    = 4;
  localparam logic [3:0] INV  = 4'b0010;
  localparam int         HOLD = 10;
  localparam int         REP  = 5;

  logic          clk;
  logic          rst;
  logic [CH-1:0] noisy_in;
  logic [CH-1:0] stable_out;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;
  logic [CH-1:0] repeat_pulse;

  int n_checks;
  int n_pass;

  // model state
  logic [CH-1:0] m_stable, m_rise, m_fall, m_rep;
  logic [CH-1:0] pipe[$];
  logic [CH-1:0] used_hist[$];
  int            hold_n[CH];

  multi_channel_debouncer #(
    .CHANNELS(CH), .CNT_W(8), .DEBOUNCE_TIME(D), .INVERT_MASK(INV),
    .HOLD_TIME(HOLD), .REPEAT_TIME(REP)
  ) dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .stable_out(stable_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .repeat_pulse(repeat_pulse)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_stable = '0; m_rise = '0; m_fall = '0; m_rep = '0;
    pipe = {};
    pipe.push_back('0);
    pipe.push_back('0);
    used_hist = {};
    for (int c = 0; c < CH; c++) hold_n[c] = 0;
  endtask

  // Output flips when the last D synchronised samples all disagree with the current level.
  task automatic model_step();
    logic [CH-1:0] used, prev;
    bit all_diff;
    used = pipe.pop_front();
    pipe.push_back(noisy_in ^ INV);
    used_hist.push_back(used);
    if (used_hist.size() > D) void'(used_hist.pop_front());
    prev = m_stable;
    m_rise = '0; m_fall = '0; m_rep = '0;
    for (int c = 0; c < CH; c++) begin
      all_diff = (used_hist.size() == D);
      foreach (used_hist[k]) if (used_hist[k][c] == prev[c]) all_diff = 0;
      if (all_diff) begin
        m_stable[c] = ~prev[c];
        m_rise[c]   = ~prev[c];
        m_fall[c]   = prev[c];
      end
`ifdef HOLD_REPEAT_EN
      if (m_stable[c] && prev[c]) begin
        hold_n[c]++;
        if (hold_n[c] >= HOLD && ((hold_n[c] - HOLD) % REP) == 0) m_rep[c] = 1'b1;
      end else begin
        hold_n[c] = 0;
      end
`endif
    end
  endtask

  // driver: advance n cycles, stepping the model and comparing all outputs at the falling edge
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_val("stable_out",   32'(stable_out),   32'(m_stable));
      check_val("rise_pulse",   32'(rise_pulse),   32'(m_rise));
      check_val("fall_pulse",   32'(fall_pulse),   32'(m_fall));
      check_val("repeat_pulse", 32'(repeat_pulse), 32'(m_rep));
    end
  endtask

  task automatic measure_edge(input int ch, input bit rising, input string tag);
    int seen;
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      run_cycles(1);
      if (seen == 0 && (rising ? rise_pulse[ch] : fall_pulse[ch])) seen = k;
    end
    check_val(tag, 32'(seen), 32'(D + 2));
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, 32'({stable_out, rise_pulse, fall_pulse, repeat_pulse}), 32'd0);
  endtask

  int run_len[CH];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    noisy_in = 4'b0010;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b1;
    run_cycles(10);
    check_val("idle_ch1_inverted", 32'(stable_out), 32'd0);

    // single rise with exact latency
    noisy_in = 4'b0011;
    measure_edge(0, 1'b1, "lat_rise_ch0");

    // ch2 bounce never settles long enough
    repeat (5) begin
      noisy_in[2] = 1'b1; run_cycles(3);
      noisy_in[2] = 1'b0; run_cycles(1);
    end
    check_val("bounce_ch2", 32'(stable_out[2]), 32'd0);

    // simultaneous rises on ch0 and ch3, then ch0 falls
    noisy_in[0] = 1'b0; run_cycles(8);
    noisy_in[0] = 1'b1; noisy_in[3] = 1'b1;
    run_cycles(D + 2);
    check_val("sim_rise", 32'(rise_pulse), 32'b1001);
    run_cycles(4);
    noisy_in[0] = 1'b0;
    measure_edge(0, 1'b0, "lat_fall_ch0");

    // reset in the middle of a count
    noisy_in = 4'b0010; run_cycles(10);
    noisy_in[0] = 1'b1; run_cycles(4);
    rst = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_count_reset");
    @(negedge clk);
    rst = 1'b1;
    measure_edge(0, 1'b1, "lat_rise_after_rst");

    // long hold (repeat behaviour)
    run_cycles(30);

    // random run lengths per channel
    for (int c = 0; c < CH; c++) run_len[c] = $urandom_range(1, 8);
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < CH; c++) begin
        run_len[c]--;
        if (run_len[c] <= 0) begin
          noisy_in[c] = noisy_in[c] ^ 1'($urandom_range(0, 1));
          run_len[c]  = $urandom_range(1, 9);
        end
      end
      run_cycles(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
